fft_bfly_sched: RTL and testbench

//  Sequencer for the in-place radix-2 DIT FFT engine. Issues one butterfly per

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_bfly_sched_if.sv | 33 +++
 rtl/fft_addr_delay.sv | 30 +++
 rtl/fft_bfly_sched.sv | 156 +++++++++++++++
 tb/tb_fft_bfly_sched.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM state encoding and bench helpers for the radix-2 DIT FFT
// butterfly sequencer.
package fft_pkg;

  localparam int FFT_LOG2N = 8;
  localparam int FFT_N     = 1 << FFT_LOG2N;
  localparam int CPLX_W    = 22;
  localparam int HALF_W    = 11;
  localparam int BF_LAT    = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // Reverses the low 'bits' bits of x; used to build bit-reversed input images.
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] x,
                                                  input int bits);
    logic [FFT_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < bits; i++) begin
      r[i] = x[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_sched_if.sv
// Control/address bundle between the butterfly sequencer (master) and the
// RAM/butterfly datapath (slave).
interface fft_bfly_sched_if #(
  parameter int LOG2N = 8
);

  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       rd_en;
  logic [LOG2N-1:0]           rd_addr_a;
  logic [LOG2N-1:0]           rd_addr_b;
  logic [LOG2N-2:0]           tw_addr;
  logic [$clog2(LOG2N)-1:0]   stage;
  logic                       wr_en;
  logic [LOG2N-1:0]           wr_addr_a;
  logic [LOG2N-1:0]           wr_addr_b;

  modport master (
    input  start,
    output busy, done,
    output rd_en, rd_addr_a, rd_addr_b, tw_addr, stage,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start,
    input  busy, done,
    input  rd_en, rd_addr_a, rd_addr_b, tw_addr, stage,
    input  wr_en, wr_addr_a, wr_addr_b
  );

endinterface

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register with asynchronous clear; carries the issue strobe
// and addresses to the write-back side after the butterfly latency.
module fft_addr_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign data_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT FFT sequencer: one butterfly issue per cycle, a drain gap
// after each stage so every write lands before the next stage reads.
module fft_bfly_sched #(
  parameter int LOG2N  = fft_pkg::FFT_LOG2N,
  parameter int BF_LAT = fft_pkg::BF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  fft_bfly_sched_if.master sched
);

  import fft_pkg::*;

  localparam int AW = LOG2N;
  localparam int TW = LOG2N - 1;
  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int DW = $clog2(BF_LAT + 1);
  localparam int PW = 1 + 2 * AW;

  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(BF_LAT - 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [SW-1:0]   s_q, s_d;
  logic [DW-1:0]   d_q, d_d;

  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_a_q, rd_a_d;
  logic [AW-1:0]   rd_b_q, rd_b_d;
  logic [TW-1:0]   tw_q, tw_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [AW-1:0]   kx, mask, pos, span;
  logic [SW-1:0]   tw_sh;
  logic [PW-1:0]   wr_bus;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    d_d     = d_q;
    case (state_q)
      S_IDLE: begin
        if (sched.start) begin
          state_d = S_RUN;
          k_d     = '0;
          s_d     = '0;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          d_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (d_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            s_d     = s_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          d_d = d_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from next-state so they appear registered in the issue cycle.
  always_comb begin
    kx      = AW'(k_d);
    span    = AW'(1) << s_d;
    mask    = span - AW'(1);
    pos     = kx & mask;
    tw_sh   = S_LAST - s_d;
    rd_en_d = (state_d == S_RUN);
    busy_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
    rd_a_d  = '0;
    rd_b_d  = '0;
    tw_d    = '0;
    stage_d = '0;
    if (rd_en_d) begin
      rd_a_d  = ((kx & ~mask) << 1) | pos;
      rd_b_d  = rd_a_d | span;
      tw_d    = TW'(pos << tw_sh);
      stage_d = s_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      d_q     <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      d_q     <= d_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  fft_addr_delay #(
    .DEPTH (BF_LAT),
    .WIDTH (PW)
  ) u_wr_delay (
    .clk    (clk),
    .rst    (rst),
    .data_i ({rd_en_q, rd_a_q, rd_b_q}),
    .data_o (wr_bus)
  );

  assign sched.busy      = busy_q;
  assign sched.done      = done_q;
  assign sched.rd_en     = rd_en_q;
  assign sched.rd_addr_a = rd_a_q;
  assign sched.rd_addr_b = rd_b_q;
  assign sched.tw_addr   = tw_q;
  assign sched.stage     = stage_q;
  assign sched.wr_en     = wr_bus[2*AW];
  assign sched.wr_addr_a = wr_bus[2*AW-1:AW];
  assign sched.wr_addr_b = wr_bus[AW-1:0];

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Scoreboard bench for fft_bfly_sched: a small N=8 instance checked cycle by cycle
// and an N=256, BF_LAT=3 instance checked for total schedule length.
module tb_fft_bfly_sched;

  localparam int SL  = 3;
  localparam int SN  = 1 << SL;
  localparam int SBF = 2;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int st;
  } issue_t;

  logic clk;
  logic rst;
  int   cyc;
  int   testsRun;
  int   testsFailed;

  issue_t rdQ[$];
  issue_t wrQ[$];
  int     doneQ[$];
  int     busyFrom;
  int     busyTo;

  int bigRd, bigWr, bigDoneCyc, bigLastA, bigLastB, bigLastTw, bigLastSt;
  bit bigDoneSeen;

  fft_bfly_sched_if #(.LOG2N(SL)) sIf ();
  fft_bfly_sched_if #(.LOG2N(8))  bIf ();

  fft_bfly_sched #(.LOG2N(SL), .BF_LAT(SBF)) dutSmall (
    .clk   (clk),
    .rst   (rst),
    .sched (sIf)
  );

  fft_bfly_sched #(.LOG2N(8), .BF_LAT(3)) dutBig (
    .clk   (clk),
    .rst   (rst),
    .sched (bIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected issue/write-back schedule for one transform started in cycle t.
  task automatic pushExpected(input int t);
    issue_t it;
    int span;
    for (int s = 0; s < SL; s++) begin
      span = 1 << s;
      for (int k = 0; k < SN / 2; k++) begin
        it.cyc = t + 1 + s * (SN / 2 + SBF) + k;
        it.a   = (k / span) * 2 * span + (k % span);
        it.b   = it.a + span;
        it.tw  = (k % span) * ((SN / 2) / span);
        it.st  = s;
        rdQ.push_back(it);
        it.cyc = it.cyc + SBF;
        wrQ.push_back(it);
      end
    end
    doneQ.push_back(t + 1 + SL * (SN / 2 + SBF));
    busyFrom = t + 1;
    busyTo   = t + 1 + SL * (SN / 2 + SBF);
  endtask

  task automatic flushExpected();
    rdQ.delete();
    wrQ.delete();
    doneQ.delete();
    busyTo = 0;
  endtask

  task automatic applyStimulus(input bit accept);
    if (accept) pushExpected(cyc);
    sIf.start = 1'b1;
    @(posedge clk);
    #1;
    sIf.start = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Small-instance monitor: every output compared against the scoreboard each cycle.
  initial begin
    issue_t cur;
    bit expRd, expWr, expDone, expBusy;
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("rst_rd_en",     32'(sIf.rd_en),     32'd0);
        checkOutput("rst_rd_addr_a", 32'(sIf.rd_addr_a), 32'd0);
        checkOutput("rst_rd_addr_b", 32'(sIf.rd_addr_b), 32'd0);
        checkOutput("rst_tw_addr",   32'(sIf.tw_addr),   32'd0);
        checkOutput("rst_stage",     32'(sIf.stage),     32'd0);
        checkOutput("rst_wr_en",     32'(sIf.wr_en),     32'd0);
        checkOutput("rst_wr_addr_a", 32'(sIf.wr_addr_a), 32'd0);
        checkOutput("rst_wr_addr_b", 32'(sIf.wr_addr_b), 32'd0);
        checkOutput("rst_busy",      32'(sIf.busy),      32'd0);
        checkOutput("rst_done",      32'(sIf.done),      32'd0);
      end else begin
        expRd = (rdQ.size() > 0) && (rdQ[0].cyc == cyc);
        checkOutput("rd_en", 32'(sIf.rd_en), 32'(expRd));
        if (expRd) begin
          cur = rdQ.pop_front();
          if (sIf.rd_en) begin
            checkOutput("rd_addr_a", 32'(sIf.rd_addr_a), 32'(cur.a));
            checkOutput("rd_addr_b", 32'(sIf.rd_addr_b), 32'(cur.b));
            checkOutput("tw_addr",   32'(sIf.tw_addr),   32'(cur.tw));
            checkOutput("stage",     32'(sIf.stage),     32'(cur.st));
          end
        end
        expWr = (wrQ.size() > 0) && (wrQ[0].cyc == cyc);
        checkOutput("wr_en", 32'(sIf.wr_en), 32'(expWr));
        if (expWr) begin
          cur = wrQ.pop_front();
          if (sIf.wr_en) begin
            checkOutput("wr_addr_a", 32'(sIf.wr_addr_a), 32'(cur.a));
            checkOutput("wr_addr_b", 32'(sIf.wr_addr_b), 32'(cur.b));
          end
        end
        expDone = (doneQ.size() > 0) && (doneQ[0] == cyc);
        checkOutput("done", 32'(sIf.done), 32'(expDone));
        if (expDone) void'(doneQ.pop_front());
        expBusy = (cyc >= busyFrom) && (cyc < busyTo);
        checkOutput("busy", 32'(sIf.busy), 32'(expBusy));
      end
    end
  end

  // Large-instance monitor: tallies issues/writes and records the done cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bIf.rd_en) begin
          bigRd++;
          bigLastA  = int'(bIf.rd_addr_a);
          bigLastB  = int'(bIf.rd_addr_b);
          bigLastTw = int'(bIf.tw_addr);
          bigLastSt = int'(bIf.stage);
        end
        if (bIf.wr_en) bigWr++;
        if (bIf.done && !bigDoneSeen) begin
          bigDoneSeen = 1'b1;
          bigDoneCyc  = cyc;
        end
      end
    end
  end

  initial begin
    int t0, t1, t2, tb0;
    testsRun    = 0;
    testsFailed = 0;
    busyFrom    = 0;
    busyTo      = 0;
    bigRd       = 0;
    bigWr       = 0;
    bigDoneCyc  = 0;
    bigDoneSeen = 1'b0;
    rst         = 1'b1;
    sIf.start   = 1'b0;
    bIf.start   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Full transform, with ignored starts during drain and during the done cycle.
    t0 = cyc;
    applyStimulus(1'b1);
    waitUntil(t0 + 5);
    applyStimulus(1'b0);
    waitUntil(t0 + 19);
    applyStimulus(1'b0);

    // Restart two cycles after done, then abort it with reset mid-stage-1.
    waitUntil(t0 + 21);
    t1 = cyc;
    applyStimulus(1'b1);
    waitUntil(t1 + 9);
    rst = 1'b1;
    flushExpected();
    @(posedge clk);
    #1;
    sIf.start = 1'b1;
    @(posedge clk);
    #1;
    sIf.start = 1'b0;
    rst       = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Clean sequence from stage 0 after the abort.
    t2 = cyc;
    applyStimulus(1'b1);
    waitUntil(t2 + 24);
    checkOutput("rd_queue_drained",   32'(rdQ.size()),   32'd0);
    checkOutput("wr_queue_drained",   32'(wrQ.size()),   32'd0);
    checkOutput("done_queue_drained", 32'(doneQ.size()), 32'd0);

    // N=256, BF_LAT=3: done in cycle 1+8*(128+3) after start.
    tb0 = cyc;
    bIf.start = 1'b1;
    @(posedge clk);
    #1;
    bIf.start = 1'b0;
    for (int i = 0; i < 1200 && !bigDoneSeen; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("big_done_seen", 32'(bigDoneSeen), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("big_done_cycle", 32'(bigDoneCyc - tb0), 32'd1049);
    checkOutput("big_issue_count", 32'(bigRd), 32'd1024);
    checkOutput("big_write_count", 32'(bigWr), 32'd1024);
    checkOutput("big_last_a",  32'(bigLastA),  32'd127);
    checkOutput("big_last_b",  32'(bigLastB),  32'd255);
    checkOutput("big_last_tw", 32'(bigLastTw), 32'd127);
    checkOutput("big_last_stage", 32'(bigLastSt), 32'd7);
    checkOutput("big_busy_after", 32'(bIf.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
